agu_seq: RTL and testbench
==========================

Name: agu_seq

Overview:
Job-level sequencer for the address generation unit. Accepts one job descriptor (base, count, loop lengths, jumps) through a valid/ready handshake. Latches the descriptor, clears the AGU, then steps it once per accepted address on a valid/ready output stream, emitting base-relative addresses and a last flag. Sits between the MVU job controller and the memory read/write ports.

Parameters:
BWADDR, 21, address bitwidth (passed to agu)
BWLENGTH, 8, loop length bitwidth (passed to agu)
NJUMPS, 5, number of jumps; loop lengths are indexed 1..NJUMPS-1
BWCOUNT, 16, bitwidth of the per-job address count

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  job descriptor valid
cfg_ready  out  1  sequencer can accept a job (IDLE)
cfg_base  in  BWADDR  address added to every AGU offset
cfg_count  in  BWCOUNT  number of addresses to emit
cfg_l  in  BWLENGTH x [NJUMPS-1:1]  loop lengths
cfg_j  in  BWADDR x [NJUMPS-1:0]  jumps (two's complement)
abort  in  1  terminate current job
addr_valid  out  1  addr is valid
addr_ready  in  1  consumer accepts addr
addr  out  BWADDR  cfg_base + AGU offset, mod 2^BWADDR; 0 when addr_valid=0
addr_last  out  1  addr is the final address of the job
addr_on_j  out  NJUMPS  one-hot jump the AGU takes after this addr; 0 when addr_valid=0
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job end (normal or aborted)

Behaviour:
- FSM states: IDLE, CLR, RUN, DONE. Reset forces IDLE and clears all registers.
- Output values while reset is asserted and after reset: cfg_ready=1, addr_valid=0, addr=0, addr_last=0, addr_on_j=0, busy=0, done=0.
- Reset takes effect asynchronously: outputs drop without waiting for a clock edge.
- IDLE: cfg_ready=1.
  - On cfg_valid&cfg_ready: latch base, count, l, j into registers. The AGU sees only the latched copies.
  - Next state is DONE if cfg_count==0, else CLR.
- CLR: drive agu.clr=1 for exactly one cycle. The AGU loads i<=l and offset<=0. Next state is RUN.
- RUN:
  - addr_valid=1; addr=base+agu.addr_out (BWADDR bits, wrap-around).
  - agu.step = addr_valid & addr_ready; addr_on_j = agu.on_j.
  - Each handshake decrements the remaining counter.
  - addr_last = (remaining==1).
  - Handshake with addr_last: next state is DONE.
- While addr_ready=0: addr, addr_last and addr_on_j stay stable, and the AGU does not step.
- DONE: done=1 for one cycle, then IDLE. cfg_ready is low in DONE.
- Latency: descriptor accepted at edge T; CLR in cycle T+1; first addr_valid in cycle T+2.
- Steady-state throughput is one address per cycle.
- abort is sampled in CLR and RUN; it is ignored in IDLE and DONE.
  - Abort in RUN in the same cycle as a handshake: the transfer counts.
  - In all abort cases the next state is DONE; addr_last is not asserted.
- The AGU has no reset. The sequencer always issues CLR before RUN, so stale AGU state never reaches addr.
- Count width: remaining is BWCOUNT bits, so the maximum job length is 2^BWCOUNT-1.

Decomposition:
- Shared package agu_pkg holds:
  - the state enum (IDLE, CLR, RUN, DONE);
  - typedefs for the length array (BWLENGTH x [NJUMPS-1:1]) and jump array (BWADDR x [NJUMPS-1:0]);
  - default parameter constants.
- One sub-module: the existing agu, instantiated once with the latched l/j. clr and step are driven by this block.

Test Plan:
1. Nested loops. base=100, l4=2, l3=1, l2=l1=0, j4=1, j3=10, j0=1000, other jumps 0, count=7, addr_ready=1.
   -> addr 100,101,102,112,113,114,1114.
   -> addr_on_j=5'b10000 at 100, 5'b01000 at 102, 5'b00001 at 114.
   -> addr_last only at 1114; done pulse one cycle after.
2. Backpressure. Scenario 1 with addr_ready toggling 1,0,1,0.
   -> identical address sequence; addr and addr_on_j held stable during every ready=0 cycle.
3. Zero count. count=0 accepted at edge T.
   -> done=1 in cycle T+1; addr_valid never asserted; cfg_ready=1 in cycle T+2.
4. Abort then new job. All l=0, j0=4, base=0, count=10; abort after 3 transfers.
   -> addresses 0,4,8; done pulse; no addr_last.
   -> Then a second job: base=0x40, j0=4, count=4 -> 0x40,0x44,0x48,0x4C, last at 0x4C (AGU cleared).
5. Wrap. base=0x1FFFFE, all l=0, j0=1, count=4.
   -> 0x1FFFFE, 0x1FFFFF, 0x000000, 0x000001.
6. Mid-job reset. Assert rst asynchronously mid-RUN.
   -> addr_valid, busy and done are 0 before the next clk edge; cfg_ready=1; a new job then runs normally from its own base.

Source files
------------

// File: rtl/agu_pkg.sv
// Shared types and default sizes for the address generation unit and its job sequencer.
package agu_pkg;
  localparam int BWADDR_DEF   = 21;
  localparam int BWLENGTH_DEF = 8;
  localparam int NJUMPS_DEF   = 5;
  localparam int BWCOUNT_DEF  = 16;

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

  typedef logic [NJUMPS_DEF-1:1][BWLENGTH_DEF-1:0] len_arr_t;
  typedef logic [NJUMPS_DEF-1:0][BWADDR_DEF-1:0]   jmp_arr_t;
endpackage

// File: rtl/agu_seq_if.sv
// Job descriptor input, address output stream and status between job controller and sequencer.
interface agu_seq_if #(
  parameter int BWADDR   = agu_pkg::BWADDR_DEF,
  parameter int BWLENGTH = agu_pkg::BWLENGTH_DEF,
  parameter int NJUMPS   = agu_pkg::NJUMPS_DEF,
  parameter int BWCOUNT  = agu_pkg::BWCOUNT_DEF
);
  logic                            cfg_valid;
  logic                            cfg_ready;
  logic [BWADDR-1:0]               cfg_base;
  logic [BWCOUNT-1:0]              cfg_count;
  logic [NJUMPS-1:1][BWLENGTH-1:0] cfg_l;
  logic [NJUMPS-1:0][BWADDR-1:0]   cfg_j;
  logic                            abort;
  logic                            addr_valid;
  logic                            addr_ready;
  logic [BWADDR-1:0]               addr;
  logic                            addr_last;
  logic [NJUMPS-1:0]               addr_on_j;
  logic                            busy;
  logic                            done;

  modport master (
    output cfg_valid, cfg_base, cfg_count, cfg_l, cfg_j, abort, addr_ready,
    input  cfg_ready, addr_valid, addr, addr_last, addr_on_j, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_base, cfg_count, cfg_l, cfg_j, abort, addr_ready,
    output cfg_ready, addr_valid, addr, addr_last, addr_on_j, busy, done
  );
endinterface

// File: rtl/agu.sv
// Nested-loop offset generator: addr_out is the current offset, on_j the jump taken on the next step.
// No reset; clr reloads the loop counters from l and zeroes the offset.
module agu #(
  parameter int BWADDR   = 21,
  parameter int BWLENGTH = 8,
  parameter int NJUMPS   = 5
) (
  input  logic                            clk,
  input  logic                            clr,
  input  logic                            step,
  input  logic [NJUMPS-1:1][BWLENGTH-1:0] l,
  input  logic [NJUMPS-1:0][BWADDR-1:0]   j,
  output logic [BWADDR-1:0]               addr_out,
  output logic [NJUMPS-1:0]               on_j
);
  logic [NJUMPS-1:1][BWLENGTH-1:0] i;
  logic [NJUMPS-1:1][BWLENGTH-1:0] i_nxt;
  logic [BWADDR-1:0]               jump_sel;
  logic                            carry;

  // Index NJUMPS-1 is the innermost loop; an exhausted loop reloads and carries outward, ending at j0.
  always_comb begin
    i_nxt = i;
    on_j  = '0;
    carry = 1'b1;
    for (int k = NJUMPS-1; k >= 1; k--) begin
      if (carry) begin
        if (i[k] != '0) begin
          i_nxt[k] = i[k] - BWLENGTH'(1);
          on_j[k]  = 1'b1;
          carry    = 1'b0;
        end else begin
          i_nxt[k] = l[k];
        end
      end
    end
    on_j[0]  = carry;
    jump_sel = '0;
    for (int k = 0; k < NJUMPS; k++) begin
      if (on_j[k]) jump_sel = j[k];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      i        <= l;
      addr_out <= '0;
    end else if (step) begin
      i        <= i_nxt;
      addr_out <= addr_out + jump_sel;
    end
  end
endmodule

// File: rtl/agu_seq.sv
// Job sequencer: latches a descriptor, clears the AGU, then streams base-relative addresses.
// First address two cycles after accept, one per cycle after; outputs hold while addr_ready is low.
module agu_seq
  import agu_pkg::*;
#(
  parameter int BWADDR   = BWADDR_DEF,
  parameter int BWLENGTH = BWLENGTH_DEF,
  parameter int NJUMPS   = NJUMPS_DEF,
  parameter int BWCOUNT  = BWCOUNT_DEF
) (
  input logic       clk,
  input logic       rst,
  agu_seq_if.slave  bus
);
  state_t                          state;
  logic [BWADDR-1:0]               base_q;
  logic [BWCOUNT-1:0]              remaining;
  logic [NJUMPS-1:1][BWLENGTH-1:0] l_q;
  logic [NJUMPS-1:0][BWADDR-1:0]   j_q;
  logic                            run;
  logic                            last;
  logic                            agu_step;
  logic [BWADDR-1:0]               agu_addr;
  logic [NJUMPS-1:0]               agu_on_j;

  assign run      = (state == RUN);
  assign last     = (remaining == BWCOUNT'(1));
  assign agu_step = run & bus.addr_ready;

  agu #(
    .BWADDR   (BWADDR),
    .BWLENGTH (BWLENGTH),
    .NJUMPS   (NJUMPS)
  ) u_agu (
    .clk      (clk),
    .clr      (state == CLR),
    .step     (agu_step),
    .l        (l_q),
    .j        (j_q),
    .addr_out (agu_addr),
    .on_j     (agu_on_j)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base_q    <= '0;
      remaining <= '0;
      l_q       <= '0;
      j_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cfg_valid) begin
            base_q    <= bus.cfg_base;
            remaining <= bus.cfg_count;
            l_q       <= bus.cfg_l;
            j_q       <= bus.cfg_j;
            state     <= (bus.cfg_count == '0) ? DONE : CLR;
          end
        end
        CLR:  state <= bus.abort ? DONE : RUN;
        RUN: begin
          // A transfer in the abort cycle still completes and is counted.
          if (agu_step) remaining <= remaining - BWCOUNT'(1);
          if (bus.abort || (agu_step && last)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs decode the state register, so reset clears them without waiting for a clock.
  assign bus.cfg_ready  = (state == IDLE);
  assign bus.addr_valid = run;
  assign bus.addr       = run ? (base_q + agu_addr) : '0;
  assign bus.addr_last  = run & last;
  assign bus.addr_on_j  = run ? agu_on_j : '0;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
endmodule

// File: tb/tb_agu_seq.sv
// Self-checking bench for agu_seq: directed test-plan scenarios plus randomized jobs vs a loop-nest model.
module tb_agu_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;

  agu_seq_if #(.BWADDR(21), .BWLENGTH(8), .NJUMPS(5), .BWCOUNT(16)) bus ();

  agu_seq #(.BWADDR(21), .BWLENGTH(8), .NJUMPS(5), .BWCOUNT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Current job as seen by the model
  logic [20:0] m_base;
  int          m_l [1:4];
  logic [20:0] m_j [0:4];

  logic [20:0] exp_a [$];
  logic [4:0]  exp_oj [$];
  logic [20:0] obs_a [$];
  logic [4:0]  obs_oj [$];
  logic        obs_last [$];
  int          stab_err, cyc_last, cyc_done, timed_out;
  logic        done_one;

  // Address s sits in a mixed-radix loop nest; the jump taken after it is the innermost loop not at its end.
  function automatic int jump_after(input int s);
    int q = s;
    for (int k = 4; k >= 1; k--) begin
      if ((q % (m_l[k] + 1)) != m_l[k]) return k;
      q = q / (m_l[k] + 1);
    end
    return 0;
  endfunction

  task automatic build_expected(input int n);
    logic [20:0] acc = m_base;
    int k;
    exp_a.delete();
    exp_oj.delete();
    for (int s = 0; s < n; s++) begin
      k = jump_after(s);
      exp_a.push_back(acc);
      exp_oj.push_back(5'(1 << k));
      acc = acc + m_j[k];
    end
  endtask

  task automatic set_flat(input logic [20:0] base, input logic [20:0] j0);
    m_base = base;
    for (int k = 1; k < 5; k++) m_l[k] = 0;
    for (int k = 0; k < 5; k++) m_j[k] = '0;
    m_j[0] = j0;
  endtask

  task automatic send_job(input int count);
    int w = 0;
    @(negedge clk);
    while (bus.cfg_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    bus.cfg_base  = m_base;
    bus.cfg_count = count[15:0];
    for (int k = 1; k < 5; k++) bus.cfg_l[k] = m_l[k][7:0];
    for (int k = 0; k < 5; k++) bus.cfg_j[k] = m_j[k];
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  // Entered on a negedge; samples each cycle mid-period and drives addr_ready for the coming edge.
  // mode 0: ready always, 1: ready toggles 1,0,..., 2: random ready.
  task automatic collect(input int mode, input int abort_at, input int max_cycles);
    logic        held = 1'b0;
    logic [20:0] ha = '0;
    logic [4:0]  hoj = '0;
    logic        hl = 1'b0;
    logic        rdy;
    int          cyc = 0;
    bit          fin = 0;
    obs_a.delete(); obs_oj.delete(); obs_last.delete();
    stab_err = 0; cyc_last = -1; cyc_done = -1; timed_out = 0;
    while (!fin) begin
      if (held && (bus.addr_valid !== 1'b1 || bus.addr !== ha || bus.addr_on_j !== hoj ||
                   bus.addr_last !== hl))
        stab_err++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.addr_ready = rdy;
      held = 1'b0;
      if (bus.done === 1'b1) begin
        cyc_done = cyc;
        fin = 1;
      end else if (bus.addr_valid === 1'b1) begin
        if (rdy) begin
          obs_a.push_back(bus.addr);
          obs_oj.push_back(bus.addr_on_j);
          obs_last.push_back(bus.addr_last);
          if (bus.addr_last === 1'b1) cyc_last = cyc;
          if (obs_a.size() == abort_at) bus.abort = 1'b1;
        end else begin
          held = 1'b1; ha = bus.addr; hoj = bus.addr_on_j; hl = bus.addr_last;
        end
      end
      if (!fin) begin
        cyc++;
        if (cyc > max_cycles) begin
          timed_out = 1;
          fin = 1;
        end
        @(negedge clk);
        bus.abort = 1'b0;
      end
    end
    @(negedge clk);
    done_one = (bus.done === 1'b0 && bus.cfg_ready === 1'b1);
    bus.addr_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if (bus.cfg_ready !== 1'b1 || bus.addr_valid !== 1'b0 || bus.addr !== 21'd0 ||
        bus.addr_last !== 1'b0 || bus.addr_on_j !== 5'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      begin errors++; $display("FAIL reset_during: rdy=%b v=%b a=%h l=%b oj=%b busy=%b done=%b, want 1 0 0 0 0 0 0",
        bus.cfg_ready, bus.addr_valid, bus.addr, bus.addr_last, bus.addr_on_j, bus.busy, bus.done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cfg_ready !== 1'b1 || bus.addr_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      begin errors++; $display("FAIL reset_after: rdy=%b v=%b busy=%b done=%b, want 1 0 0 0",
        bus.cfg_ready, bus.addr_valid, bus.busy, bus.done); end
  endtask

  task automatic test_nested();
    int ea [7] = '{100, 101, 102, 112, 113, 114, 1114};
    int eo [7] = '{16, 16, 8, 16, 16, 1, 16};
    m_base = 21'd100;
    m_l[4] = 2; m_l[3] = 1; m_l[2] = 0; m_l[1] = 0;
    m_j[4] = 21'd1; m_j[3] = 21'd10; m_j[2] = '0; m_j[1] = '0; m_j[0] = 21'd1000;
    send_job(7);
    checks++;
    if (bus.busy !== 1'b1 || bus.addr_valid !== 1'b0 || bus.cfg_ready !== 1'b0)
      begin errors++; $display("FAIL nested_clr_cycle: busy=%b v=%b rdy=%b, want 1 0 0",
        bus.busy, bus.addr_valid, bus.cfg_ready); end
    collect(0, -1, 100);
    checks++;
    if (timed_out !== 0 || obs_a.size() != 7)
      begin errors++; $display("FAIL nested_len: got %0d addrs timeout=%0d, want 7", obs_a.size(), timed_out); end
    for (int n = 0; n < 7 && n < obs_a.size(); n++) begin
      checks++;
      if (obs_a[n] !== 21'(ea[n]) || obs_oj[n] !== 5'(eo[n]) || obs_last[n] !== (n == 6))
        begin errors++; $display("FAIL nested_addr[%0d]: addr=%0d oj=%b last=%b, want %0d %b %b",
          n, obs_a[n], obs_oj[n], obs_last[n], ea[n], 5'(eo[n]), (n == 6)); end
    end
    checks++;
    if (cyc_done - cyc_last != 1 || done_one !== 1'b1)
      begin errors++; $display("FAIL nested_done: done-last=%0d single=%b, want 1 1", cyc_done - cyc_last, done_one); end
  endtask

  task automatic test_backpressure();
    build_expected(7);
    send_job(7);
    collect(1, -1, 100);
    checks++;
    if (timed_out !== 0 || obs_a.size() != 7 || stab_err != 0)
      begin errors++; $display("FAIL bp_stream: n=%0d stab_err=%0d timeout=%0d, want 7 0 0",
        obs_a.size(), stab_err, timed_out); end
    for (int n = 0; n < 7 && n < obs_a.size(); n++) begin
      checks++;
      if (obs_a[n] !== exp_a[n] || obs_oj[n] !== exp_oj[n] || obs_last[n] !== (n == 6))
        begin errors++; $display("FAIL bp_addr[%0d]: addr=%0d oj=%b last=%b, want %0d %b %b",
          n, obs_a[n], obs_oj[n], obs_last[n], exp_a[n], exp_oj[n], (n == 6)); end
    end
  endtask

  task automatic test_zero_count();
    set_flat(21'd5, 21'd1);
    send_job(0);
    checks++;
    if (bus.done !== 1'b1 || bus.addr_valid !== 1'b0)
      begin errors++; $display("FAIL zero_done: done=%b v=%b, want 1 0", bus.done, bus.addr_valid); end
    @(negedge clk);
    checks++;
    if (bus.cfg_ready !== 1'b1 || bus.done !== 1'b0 || bus.addr_valid !== 1'b0)
      begin errors++; $display("FAIL zero_idle: rdy=%b done=%b v=%b, want 1 0 0",
        bus.cfg_ready, bus.done, bus.addr_valid); end
  endtask

  task automatic test_abort();
    bit any_last = 0;
    set_flat(21'd0, 21'd4);
    build_expected(3);
    send_job(10);
    collect(0, 3, 100);
    foreach (obs_last[n]) if (obs_last[n]) any_last = 1;
    checks++;
    if (timed_out !== 0 || obs_a.size() != 3 || any_last || cyc_done < 0)
      begin errors++; $display("FAIL abort_stream: n=%0d last_seen=%0d done_cyc=%0d, want 3 0 >=0",
        obs_a.size(), any_last, cyc_done); end
    for (int n = 0; n < 3 && n < obs_a.size(); n++) begin
      checks++;
      if (obs_a[n] !== exp_a[n])
        begin errors++; $display("FAIL abort_addr[%0d]: %0d, want %0d", n, obs_a[n], exp_a[n]); end
    end
    set_flat(21'h40, 21'd4);
    build_expected(4);
    send_job(4);
    collect(0, -1, 100);
    checks++;
    if (obs_a.size() != 4)
      begin errors++; $display("FAIL abort_next_len: %0d, want 4", obs_a.size()); end
    for (int n = 0; n < 4 && n < obs_a.size(); n++) begin
      checks++;
      if (obs_a[n] !== exp_a[n] || obs_last[n] !== (n == 3))
        begin errors++; $display("FAIL abort_next[%0d]: addr=%h last=%b, want %h %b",
          n, obs_a[n], obs_last[n], exp_a[n], (n == 3)); end
    end
  endtask

  task automatic test_wrap();
    int ea [4] = '{32'h1FFFFE, 32'h1FFFFF, 0, 1};
    set_flat(21'h1FFFFE, 21'd1);
    send_job(4);
    collect(0, -1, 100);
    checks++;
    if (obs_a.size() != 4)
      begin errors++; $display("FAIL wrap_len: %0d, want 4", obs_a.size()); end
    for (int n = 0; n < 4 && n < obs_a.size(); n++) begin
      checks++;
      if (obs_a[n] !== 21'(ea[n]))
        begin errors++; $display("FAIL wrap_addr[%0d]: %h, want %h", n, obs_a[n], 21'(ea[n])); end
    end
  endtask

  task automatic test_midreset();
    set_flat(21'h500, 21'd2);
    bus.addr_ready = 1'b1;
    send_job(20);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.addr_valid !== 1'b1)
      begin errors++; $display("FAIL midrst_running: v=%b, want 1", bus.addr_valid); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.addr_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.cfg_ready !== 1'b1 || bus.addr !== 21'd0)
      begin errors++; $display("FAIL midrst_async: v=%b busy=%b done=%b rdy=%b a=%h, want 0 0 0 1 0",
        bus.addr_valid, bus.busy, bus.done, bus.cfg_ready, bus.addr); end
    @(negedge clk);
    rst = 1'b0;
    bus.addr_ready = 1'b0;
    set_flat(21'h7000, 21'd3);
    build_expected(5);
    send_job(5);
    collect(0, -1, 100);
    checks++;
    if (obs_a.size() != 5)
      begin errors++; $display("FAIL midrst_len: %0d, want 5", obs_a.size()); end
    for (int n = 0; n < 5 && n < obs_a.size(); n++) begin
      checks++;
      if (obs_a[n] !== exp_a[n] || obs_last[n] !== (n == 4))
        begin errors++; $display("FAIL midrst_addr[%0d]: %h last=%b, want %h %b",
          n, obs_a[n], obs_last[n], exp_a[n], (n == 4)); end
    end
  endtask

  task automatic test_random();
    int cnt;
    for (int t = 0; t < 8; t++) begin
      m_base = 21'($urandom);
      for (int k = 1; k < 5; k++) m_l[k] = $urandom_range(0, 2);
      for (int k = 0; k < 5; k++) m_j[k] = 21'($urandom);
      cnt = $urandom_range(1, 20);
      build_expected(cnt);
      send_job(cnt);
      collect(2, -1, 300);
      checks++;
      if (timed_out !== 0 || obs_a.size() != cnt || stab_err != 0 || cyc_done - cyc_last != 1)
        begin errors++; $display("FAIL rand%0d_stream: n=%0d want %0d stab_err=%0d done-last=%0d timeout=%0d",
          t, obs_a.size(), cnt, stab_err, cyc_done - cyc_last, timed_out); end
      for (int n = 0; n < cnt && n < obs_a.size(); n++) begin
        checks++;
        if (obs_a[n] !== exp_a[n] || obs_oj[n] !== exp_oj[n] || obs_last[n] !== (n == cnt - 1))
          begin errors++; $display("FAIL rand%0d_addr[%0d]: addr=%h oj=%b last=%b, want %h %b %b",
            t, n, obs_a[n], obs_oj[n], obs_last[n], exp_a[n], exp_oj[n], (n == cnt - 1)); end
      end
    end
  endtask

  initial begin
    bus.cfg_valid  = 1'b0;
    bus.cfg_base   = '0;
    bus.cfg_count  = '0;
    bus.cfg_l      = '0;
    bus.cfg_j      = '0;
    bus.abort      = 1'b0;
    bus.addr_ready = 1'b0;
    test_reset();
    test_nested();
    test_backpressure();
    test_zero_count();
    test_abort();
    test_wrap();
    test_midreset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
